water_supply_arbiter: RTL and testbench
=======================================

# water_supply_arbiter

Shares one mains water inlet among up to eight washing machine controllers. Each machine raises a request while its water valve must be open. The arbiter grants the inlet to exactly one machine at a time, using round-robin order. Between owners it inserts a fixed dead time so valves can settle, and it can optionally pre-empt an owner that holds the inlet too long. It sits between the per-machine FSMs and the shared inlet solenoid driver.

## Interface
- `N_MACH`, default 4: number of requesters, legal range 2..8.
- `MAX_GRANT`, default 8'd200: maximum consecutive cycles one owner may hold the inlet, legal range 1..255. Used only with the timeout feature.
- `GAP_CYCLES`, default 4'd2: dead cycles between any grant deassertion and the next grant, legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in N_MACH: per-machine water request, level; held high while the machine needs water.
- `grant` out N_MACH: one-hot or zero, registered.
- `grant_id` out 3: index of the current owner; 0 when no grant.
- `supply_valve` out 1: shared inlet solenoid; equals OR of `grant`.
- `busy` out 1: high in GRANTED or GAP.
- `timeout` out 1: one-cycle pulse when an owner is pre-empted.

## Operation
- States:
  - IDLE: no owner, valve closed.
  - GRANTED: one owner, valve open.
  - GAP: dead time, valve closed.
- IDLE:
  - If any `req` bit is high, select a winner and go to GRANTED next cycle.
  - Otherwise stay in IDLE.
- Winner selection:
  - Search starts at index `rr_ptr` and wraps modulo N_MACH; the first set `req` bit wins.
  - On each grant, `rr_ptr` becomes winner+1 (mod N_MACH).
  - `rr_ptr` resets to 0, so index 0 has the highest priority after reset.
- GRANTED:
  - `grant[owner]=1`, `supply_valve=1`, `grant_id=owner`.
  - An 8-bit hold counter starts at 1 in the first grant cycle and increments each cycle.
  - Request drop: if `req[owner]` is sampled low, go to GAP. Other requests never cause pre-emption.
  - Timeout (with `WATER_ARB_TIMEOUT_EN`): if the counter equals MAX_GRANT while `req[owner]` is still high, go to GAP and pulse `timeout` in the first GAP cycle.
- GAP:
  - All grants are 0 and `supply_valve=0`. The gap counter loads GAP_CYCLES and decrements.
  - In the last GAP cycle, arbitrate exactly as in IDLE. Go to GRANTED if any `req` bit is high, otherwise go to IDLE.
  - A pre-empted owner keeps requesting and is reconsidered in normal round-robin order. Because `rr_ptr` has already moved past it, other pending requesters are served first. If it is the only requester, it is re-granted after the gap.
- Request bits for non-owners may toggle freely; only their value at arbitration time matters.
- Reset:
  - `reset` high at any edge, including mid-grant, forces IDLE on the following cycle.
  - It clears `grant=0`, `grant_id=0`, `supply_valve=0`, `busy=0`, `timeout=0`, `rr_ptr=0` and both counters.
  - No GAP is inserted after reset.

## Timing
- All outputs are registered; there is no combinational path from `req` to `grant`.
- Grant latency: a request sampled at edge t in IDLE gives `grant` high from t+1.
- Release: `req[owner]` sampled low at edge t gives `grant` low from t+1. `grant` stays low for exactly GAP_CYCLES cycles, and the next grant rises at t+1+GAP_CYCLES.
- Timeout: `grant` is high for exactly MAX_GRANT cycles. `timeout` is high in the first cycle that `grant` is low.
- Simultaneous release and timeout in the same cycle is treated as a release: no `timeout` pulse.
- `grant` never has more than one bit set. `supply_valve` never changes in the same cycle as an owner change (the GAP guarantees this).

## Configuration
- Macro `WATER_ARB_TIMEOUT_EN`.
- Defined: the MAX_GRANT pre-emption described above is active.
- Undefined:
  - The hold counter and timeout logic are omitted.
  - An owner keeps the grant until it drops `req`.
  - `timeout` is tied to 0.
  - MAX_GRANT is ignored.

## Test plan
- Reset, then `req=4'b0100` held for 10 cycles and dropped:
  - `grant=4'b0100` and `grant_id=2`, starting one cycle after `req` rises.
  - Grant lasts 10 cycles; `supply_valve` matches `grant`.
  - `busy` stays high for 2 more cycles, then IDLE.
- `req=4'b1111`, each owner releasing after 3 cycles:
  - Grant order is 0,1,2,3,0.
  - Exactly 2 zero-grant cycles separate consecutive grants.
- Timeout enabled, MAX_GRANT=5, `req=4'b0011` held:
  - Machine 0 is granted for 5 cycles; `timeout` pulses once.
  - After the 2-cycle gap, machine 1 is granted.
  - After machine 1's 5 cycles, machine 0 is granted again.
- Timeout disabled, same stimulus:
  - Machine 0 holds the grant indefinitely (checked over 300 cycles).
  - `timeout` stays 0.
- `reset` asserted in the third cycle of a grant to machine 3:
  - Next cycle: `grant=0`, `supply_valve=0`, `busy=0`.
  - With `req=4'b1000` still high after reset releases, `grant=4'b1000` returns one cycle after the first non-reset edge.
- Owner releases while `req=4'b0110` and `rr_ptr=2` (last grant was to machine 1):
  - Machine 2 wins after the gap, then machine 1.

Source files
------------

// File: rtl/water_supply_arbiter_if.sv
// Handshake bundle between the per-machine controllers (master) and the
// shared-inlet arbiter (slave).
interface water_supply_arbiter_if #(
   parameter int N_MACH = 4
);
   logic [N_MACH-1:0] req;
   logic [N_MACH-1:0] grant;
   logic [2:0]        grant_id;
   logic              supply_valve;
   logic              busy;
   logic              timeout;

   modport master (
      output req,
      input  grant, grant_id, supply_valve, busy, timeout
   );

   modport slave (
      input  req,
      output grant, grant_id, supply_valve, busy, timeout
   );
endinterface

// File: rtl/water_supply_arbiter.sv
// Round-robin owner of the shared mains inlet with a settle gap between owners.
// Define WATER_ARB_TIMEOUT_EN to pre-empt an owner after MAX_GRANT cycles.
//
// state   | meaning
// IDLE    | no owner, valve closed
// GRANTED | one owner, valve open
// GAP     | dead time between owners, valve closed
module water_supply_arbiter #(
   parameter int         N_MACH     = 4,
   parameter logic [7:0] MAX_GRANT  = 8'd200,
   parameter logic [3:0] GAP_CYCLES = 4'd2
) (
   input logic                   clk,
   input logic                   reset,
   water_supply_arbiter_if.slave arb
);
   typedef enum logic [1:0] {IDLE, GRANTED, GAP} state_t;

   state_t            state;
   logic [N_MACH-1:0] grant_r;
   logic [2:0]        grant_id_r;
   logic              supply_valve_r;
   logic              busy_r;
   logic              timeout_r;
   logic [2:0]        rr_ptr;
   logic [3:0]        gap_cnt;
`ifdef WATER_ARB_TIMEOUT_EN
   logic [7:0]        hold_cnt;
`endif

   logic              any_req;
   logic              owner_req;
   logic [2:0]        win_idx;
   logic [2:0]        next_ptr;
   logic [N_MACH-1:0] win_onehot;

   // Rotating priority: the i-th candidate is (rr_ptr + i) mod N_MACH.
   always_comb begin
      any_req = 1'b0;
      win_idx = '0;
      for (int i = 0; i < N_MACH; i++) begin
         for (int j = 0; j < N_MACH; j++) begin
            if (!any_req && arb.req[j] &&
                ((j == int'(rr_ptr) + i) || (j + N_MACH == int'(rr_ptr) + i))) begin
               any_req = 1'b1;
               win_idx = 3'(j);
            end
         end
      end
      next_ptr = (win_idx == 3'(N_MACH - 1)) ? 3'd0 : win_idx + 3'd1;
      for (int k = 0; k < N_MACH; k++) begin
         win_onehot[k] = (win_idx == 3'(k));
      end
      owner_req = |(arb.req & grant_r);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         grant_r        <= '0;
         grant_id_r     <= '0;
         supply_valve_r <= 1'b0;
         busy_r         <= 1'b0;
         timeout_r      <= 1'b0;
         rr_ptr         <= '0;
         gap_cnt        <= '0;
`ifdef WATER_ARB_TIMEOUT_EN
         hold_cnt       <= '0;
`endif
      end else begin
         timeout_r <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state          <= GRANTED;
                  grant_r        <= win_onehot;
                  grant_id_r     <= win_idx;
                  supply_valve_r <= 1'b1;
                  busy_r         <= 1'b1;
                  rr_ptr         <= next_ptr;
`ifdef WATER_ARB_TIMEOUT_EN
                  hold_cnt       <= 8'd1;
`endif
               end
            end

            GRANTED: begin
               // A release wins over a coincident timeout, so no pulse then.
               if (!owner_req) begin
                  state          <= GAP;
                  grant_r        <= '0;
                  grant_id_r     <= '0;
                  supply_valve_r <= 1'b0;
                  gap_cnt        <= GAP_CYCLES;
`ifdef WATER_ARB_TIMEOUT_EN
               end else if (hold_cnt == MAX_GRANT) begin
                  state          <= GAP;
                  grant_r        <= '0;
                  grant_id_r     <= '0;
                  supply_valve_r <= 1'b0;
                  gap_cnt        <= GAP_CYCLES;
                  timeout_r      <= 1'b1;
               end else begin
                  hold_cnt       <= hold_cnt + 8'd1;
`endif
               end
            end

            GAP: begin
               if (gap_cnt > 4'd1) begin
                  gap_cnt <= gap_cnt - 4'd1;
               end else begin
                  gap_cnt <= '0;
                  if (any_req) begin
                     state          <= GRANTED;
                     grant_r        <= win_onehot;
                     grant_id_r     <= win_idx;
                     supply_valve_r <= 1'b1;
                     rr_ptr         <= next_ptr;
`ifdef WATER_ARB_TIMEOUT_EN
                     hold_cnt       <= 8'd1;
`endif
                  end else begin
                     state  <= IDLE;
                     busy_r <= 1'b0;
                  end
               end
            end

            default: begin
               state          <= IDLE;
               grant_r        <= '0;
               grant_id_r     <= '0;
               supply_valve_r <= 1'b0;
               busy_r         <= 1'b0;
            end
         endcase
      end
   end

   assign arb.grant        = grant_r;
   assign arb.grant_id     = grant_id_r;
   assign arb.supply_valve = supply_valve_r;
   assign arb.busy         = busy_r;
   assign arb.timeout      = timeout_r;

endmodule

// File: tb/tb_water_supply_arbiter.sv
// Bench for water_supply_arbiter: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_water_supply_arbiter;
   localparam int N    = 4;
   localparam int MAXG = 5;
   localparam int GAP  = 2;
`ifdef WATER_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   water_supply_arbiter_if #(.N_MACH(N)) bus ();

   water_supply_arbiter #(
      .N_MACH    (N),
      .MAX_GRANT (8'(MAXG)),
      .GAP_CYCLES(4'(GAP))
   ) dut (
      .clk  (clk),
      .reset(reset),
      .arb  (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: current owner (-1 = none), cycles held, gap cycles left,
   // round-robin start index and the timeout pulse of the current cycle.
   int m_owner, m_hold, m_gap, m_ptr;
   bit m_to;

   function automatic void model_reset();
      m_owner = -1;
      m_hold  = 0;
      m_gap   = 0;
      m_ptr   = 0;
      m_to    = 1'b0;
   endfunction

   function automatic void model_step(input logic [3:0] r);
      m_to = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_owner = -1;
            m_gap   = GAP;
         end else if (TO_EN && m_hold == MAXG) begin
            m_owner = -1;
            m_gap   = GAP;
            m_to    = 1'b1;
         end else begin
            m_hold++;
         end
      end else if (m_gap > 1) begin
         m_gap--;
      end else begin
         m_gap = 0;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (m_owner < 0 && r[c]) begin
               m_owner = c;
               m_hold  = 1;
               m_ptr   = (c + 1) % N;
            end
         end
      end
   endfunction

   function automatic logic [9:0] exp_vec();
      logic [3:0] g;
      logic [2:0] id;
      g  = '0;
      id = '0;
      if (m_owner >= 0) begin
         g[m_owner] = 1'b1;
         id         = 3'(m_owner);
      end
      return {g, id, 1'(m_owner >= 0), 1'((m_owner >= 0) || (m_gap > 0)), m_to};
   endfunction

   function automatic logic [9:0] obs_vec();
      return {bus.grant, bus.grant_id, bus.supply_valve, bus.busy, bus.timeout};
   endfunction

   // One clock: drive inputs, let the edge happen, advance the model, settle.
   task automatic step(input logic [3:0] r, input logic rst);
      bus.req = r;
      reset   = rst;
      @(posedge clk);
      if (rst) model_reset();
      else     model_step(r);
      #1;
   endtask

   task automatic do_reset();
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);
   endtask

   task automatic test_reset();
      step(4'b1111, 1'b1);
      step(4'b1010, 1'b1);
      checks++;
      if (obs_vec() !== 10'b0) begin
         failures++;
         $display("FAIL reset_outputs actual=%b required=%b", obs_vec(), 10'b0);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL reset_model actual=%b required=%b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_single_request();
      int hold_len, grant_cycles, gap_busy;
      hold_len     = TO_EN ? MAXG - 1 : 10;
      grant_cycles = 0;
      gap_busy     = 0;
      do_reset();
      for (int c = 0; c < hold_len; c++) begin
         step(4'b0100, 1'b0);
         if (c == 0) begin
            checks++;
            if (bus.grant !== 4'b0100 || bus.grant_id !== 3'd2) begin
               failures++;
               $display("FAIL single_first actual=%b/%0d required=0100/2", bus.grant, bus.grant_id);
            end
         end
         if (bus.grant == 4'b0100) grant_cycles++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL single_hold actual=%b required=%b", obs_vec(), exp_vec());
         end
      end
      for (int c = 0; c < 4; c++) begin
         step(4'b0000, 1'b0);
         if (bus.busy && bus.grant == 4'b0) gap_busy++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL single_release actual=%b required=%b", obs_vec(), exp_vec());
         end
      end
      checks++;
      if (grant_cycles != hold_len) begin
         failures++;
         $display("FAIL single_length actual=%0d required=%0d", grant_cycles, hold_len);
      end
      checks++;
      if (gap_busy != GAP || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL single_gap actual=%0d/%b required=%0d/0", gap_busy, bus.busy, GAP);
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      int gaps[$];
      int zero_run;
      logic [3:0] r;
      logic [3:0] prev_grant;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      zero_run   = 0;
      prev_grant = '0;
      do_reset();
      for (int c = 0; c < 40 && order.size() < 5; c++) begin
         r = 4'b1111;
         if (m_owner >= 0 && m_hold == 3) r[m_owner] = 1'b0;
         step(r, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL rr_cycle actual=%b required=%b", obs_vec(), exp_vec());
         end
         if (bus.grant != 4'b0 && prev_grant == 4'b0) begin
            order.push_back(int'(bus.grant_id));
            if (order.size() > 1) gaps.push_back(zero_run);
         end
         zero_run   = (bus.grant == 4'b0) ? zero_run + 1 : 0;
         prev_grant = bus.grant;
      end
      checks++;
      if (order.size() != 5) begin
         failures++;
         $display("FAIL rr_count actual=%0d required=5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (order[i] != exp_order[i]) begin
               failures++;
               $display("FAIL rr_order idx=%0d actual=%0d required=%0d", i, order[i], exp_order[i]);
            end
         end
      end
      foreach (gaps[i]) begin
         checks++;
         if (gaps[i] != GAP) begin
            failures++;
            $display("FAIL rr_gap idx=%0d actual=%0d required=%0d", i, gaps[i], GAP);
         end
      end
   endtask

`ifdef WATER_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int order[$];
      int lens[$];
      int to_count, to_misplaced;
      logic [3:0] prev_grant;
      to_count     = 0;
      to_misplaced = 0;
      prev_grant   = '0;
      do_reset();
      for (int c = 0; c < 16; c++) begin
         step(4'b0011, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL timeout_cycle actual=%b required=%b", obs_vec(), exp_vec());
         end
         if (bus.timeout) begin
            to_count++;
            if (!(prev_grant != 4'b0 && bus.grant == 4'b0)) to_misplaced++;
         end
         if (bus.grant != 4'b0) begin
            if (prev_grant == 4'b0) begin
               order.push_back(int'(bus.grant_id));
               lens.push_back(1);
            end else begin
               lens[lens.size() - 1]++;
            end
         end
         prev_grant = bus.grant;
      end
      checks++;
      if (order.size() < 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
         failures++;
         $display("FAIL timeout_order actual=%p required=0,1,0", order);
      end
      checks++;
      if (lens.size() < 2 || lens[0] != MAXG || lens[1] != MAXG) begin
         failures++;
         $display("FAIL timeout_length actual=%p required=%0d,%0d", lens, MAXG, MAXG);
      end
      checks++;
      if (to_count != 2 || to_misplaced != 0) begin
         failures++;
         $display("FAIL timeout_pulse actual=%0d/%0d required=2/0", to_count, to_misplaced);
      end
   endtask
`else
   task automatic test_no_timeout();
      int bad_grant, to_seen;
      bad_grant = 0;
      to_seen   = 0;
      do_reset();
      for (int c = 0; c < 300; c++) begin
         step(4'b0011, 1'b0);
         if (bus.grant !== 4'b0001) bad_grant++;
         if (bus.timeout !== 1'b0) to_seen++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL hold_cycle actual=%b required=%b", obs_vec(), exp_vec());
         end
      end
      checks++;
      if (bad_grant != 0 || to_seen != 0) begin
         failures++;
         $display("FAIL hold_forever actual=%0d/%0d required=0/0", bad_grant, to_seen);
      end
   endtask
`endif

   task automatic test_reset_mid_grant();
      do_reset();
      for (int c = 0; c < 3; c++) step(4'b1000, 1'b0);
      checks++;
      if (bus.grant !== 4'b1000 || bus.grant_id !== 3'd3) begin
         failures++;
         $display("FAIL midreset_pre actual=%b/%0d required=1000/3", bus.grant, bus.grant_id);
      end
      step(4'b1000, 1'b1);
      checks++;
      if (bus.grant !== 4'b0 || bus.supply_valve !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL midreset_clear actual=%b/%b/%b required=0000/0/0",
                  bus.grant, bus.supply_valve, bus.busy);
      end
      step(4'b1000, 1'b0);
      checks++;
      if (bus.grant !== 4'b1000 || bus.supply_valve !== 1'b1) begin
         failures++;
         $display("FAIL midreset_regrant actual=%b/%b required=1000/1", bus.grant, bus.supply_valve);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL midreset_model actual=%b required=%b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_pointer_order();
      logic [3:0] seq[13] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0110, 4'b0110, 4'b0110,
                              4'b0110, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
      int order[$];
      logic [3:0] prev_grant;
      prev_grant = '0;
      do_reset();
      foreach (seq[i]) begin
         step(seq[i], 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL ptr_cycle idx=%0d actual=%b required=%b", i, obs_vec(), exp_vec());
         end
         if (bus.grant != 4'b0 && prev_grant == 4'b0) order.push_back(int'(bus.grant_id));
         prev_grant = bus.grant;
      end
      checks++;
      if (order.size() != 3 || order[0] != 1 || order[1] != 2 || order[2] != 1) begin
         failures++;
         $display("FAIL ptr_order actual=%p required=1,2,1", order);
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic       rst;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         r   = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 63) == 0);
         if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
         step(r, rst);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL rand_cycle c=%0d actual=%b required=%b", c, obs_vec(), exp_vec());
         end
         checks++;
         if (!$onehot0(bus.grant) || bus.supply_valve !== (|bus.grant)) begin
            failures++;
            $display("FAIL rand_invariant c=%0d grant=%b valve=%b", c, bus.grant, bus.supply_valve);
         end
      end
   endtask

   initial begin
      bus.req = '0;
      model_reset();
      test_reset();
      test_single_request();
      test_round_robin();
`ifdef WATER_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid_grant();
      test_pointer_order();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
